// File: rtl/div_pkg.sv
// div_pkg: shared types and helpers for the RV32M divider.
//   div_op_e    : DIV / DIVU / REM / REMU encodings (op_i of div_unit).
//   div_state_e : divider control states.
//   INT_MIN     : most negative DIV_XLEN-bit value (signed-overflow operand).
//   negate()    : two's-complement negation at DIV_XLEN bits.
// Optional build macro used by div_unit: DIV_EARLY_OUT_EN.
package div_pkg;

   localparam int DIV_XLEN = 32;

   typedef enum logic [1:0] {
      DIV  = 2'b00,
      DIVU = 2'b01,
      REM  = 2'b10,
      REMU = 2'b11
   } div_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      DONE = 2'b10
   } div_state_e;

   localparam logic [DIV_XLEN-1:0] INT_MIN = {1'b1, {(DIV_XLEN-1){1'b0}}};

   function automatic logic [DIV_XLEN-1:0] negate(input logic [DIV_XLEN-1:0] v);
      return (~v) + DIV_XLEN'(1);
   endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one combinational radix-2 restoring division iteration.
// Ports:
//   rem      in  : partial remainder before this step
//   quo      in  : dividend/quotient shift register before this step
//   divisor  in  : divisor magnitude
//   rem_next out : partial remainder after this step
//   quo_next out : quotient register after this step (new bit in LSB)
module div_step
   import div_pkg::*;
#(
   parameter int XLEN = DIV_XLEN
) (
   input  logic [XLEN-1:0] rem,
   input  logic [XLEN-1:0] quo,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] rem_next,
   output logic [XLEN-1:0] quo_next
);

   logic [XLEN:0] shifted;
   logic [XLEN:0] trial;

   // rem < divisor always holds, so the shifted remainder fits in XLEN+1 bits
   // and the trial MSB is a reliable borrow/negative flag.
   assign shifted  = {rem, quo[XLEN-1]};
   assign trial    = shifted - {1'b0, divisor};
   assign rem_next = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
   assign quo_next = {quo[XLEN-2:0], ~trial[XLEN]};

endmodule

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Ports:
//   clk      in  : clock, rising edge
//   rst_n    in  : asynchronous active-low reset
//   start_i  in  : divide instruction valid in E, held while stalled
//   op_i     in  : 00 DIV, 01 DIVU, 10 REM, 11 REMU (sampled with start)
//   a_i      in  : dividend (sampled with start)
//   b_i      in  : divisor (sampled with start)
//   abort_i  in  : kill any in-flight operation
//   busy_o   out : stall request to the hazard unit (combinational)
//   done_o   out : result valid this cycle
//   result_o out : registered quotient or remainder
// Build macro DIV_EARLY_OUT_EN: when defined, |a| < |b| finishes in one cycle.
// XLEN must equal div_pkg::DIV_XLEN (package helpers are sized to it).
module div_unit
   import div_pkg::*;
#(
   parameter int XLEN = DIV_XLEN
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start_i,
   input  logic [1:0]      op_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   input  logic            abort_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);

   localparam int CW = $clog2(XLEN);

   div_state_e      state, next_state;
   div_op_e         op;
   logic            sign_a, sign_b;
   logic [XLEN-1:0] rem, quo, divisor;
   logic [CW-1:0]   count;
   logic [XLEN-1:0] result;

   // Decode of the incoming operands (valid while IDLE)
   logic            in_signed, in_is_rem, in_sign_a, in_sign_b;
   logic [XLEN-1:0] mag_a, mag_b;
   logic            div_zero, overflow, early, special, accept, last;
   logic [XLEN-1:0] special_result;

   logic [XLEN-1:0] step_rem, step_quo, fix_quo, fix_rem;

   assign in_signed = ~op_i[0];
   assign in_is_rem = op_i[1];
   assign in_sign_a = in_signed & a_i[XLEN-1];
   assign in_sign_b = in_signed & b_i[XLEN-1];
   assign mag_a     = in_sign_a ? negate(a_i) : a_i;
   assign mag_b     = in_sign_b ? negate(b_i) : b_i;
   assign div_zero  = (b_i == '0);
   assign overflow  = in_signed & (a_i == INT_MIN) & (b_i == '1);

`ifdef DIV_EARLY_OUT_EN
   assign early = ~div_zero & (mag_a < mag_b);
`else
   assign early = 1'b0;
`endif

   assign special = div_zero | overflow | early;

   // Early-out shares the divide-by-zero remainder (a unchanged) and gives q=0.
   always_comb begin
      special_result = '0;
      if (div_zero)
         special_result = in_is_rem ? a_i : '1;
      else if (overflow)
         special_result = in_is_rem ? '0 : INT_MIN;
      else
         special_result = in_is_rem ? a_i : '0;
   end

   assign accept = (state == IDLE) & start_i & ~abort_i;
   assign last   = (count == CW'(XLEN-1));

   div_step #(.XLEN(XLEN)) u_step (
      .rem      (rem),
      .quo      (quo),
      .divisor  (divisor),
      .rem_next (step_rem),
      .quo_next (step_quo)
   );

   // sign_a/sign_b are already gated by the signed-op flag when latched.
   assign fix_quo = (sign_a ^ sign_b) ? negate(step_quo) : step_quo;
   assign fix_rem = sign_a ? negate(step_rem) : step_rem;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= next_state;
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      if (abort_i) begin
         next_state = IDLE;
      end else begin
         case (state)
            IDLE:    if (start_i) next_state = special ? DONE : CALC;
            CALC:    if (last)    next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
         endcase
      end
   end

   // Outputs
   always_comb begin
      busy_o = accept | (state == CALC);
      done_o = (state == DONE);
   end

   // Operand / working registers and the registered result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op      <= DIV;
         sign_a  <= 1'b0;
         sign_b  <= 1'b0;
         rem     <= '0;
         quo     <= '0;
         divisor <= '0;
         count   <= '0;
         result  <= '0;
      end else if (!abort_i) begin
         case (state)
            IDLE: begin
               if (start_i) begin
                  op      <= div_op_e'(op_i);
                  sign_a  <= in_sign_a;
                  sign_b  <= in_sign_b;
                  divisor <= mag_b;
                  rem     <= '0;
                  quo     <= mag_a;
                  count   <= '0;
                  if (special)
                     result <= special_result;
               end
            end
            CALC: begin
               rem   <= step_rem;
               quo   <= step_quo;
               count <= count + CW'(1);
               if (last)
                  result <= op[1] ? fix_rem : fix_quo;
            end
            default: ;
         endcase
      end
   end

   assign result_o = result;

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_i = 1'b0;
   logic [1:0]  op_i = 2'b00;
   logic [31:0] a_i = '0;
   logic [31:0] b_i = '0;
   logic        abort_i = 1'b0;
   logic        busy_o, done_o;
   logic [31:0] result_o;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_q[$];
   logic [31:0] last_result = '0;
   logic [31:0] mon_exp;

   always #5 clk = ~clk;

   div_unit #(.XLEN(32)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start_i  (start_i),
      .op_i     (op_i),
      .a_i      (a_i),
      .b_i      (b_i),
      .abort_i  (abort_i),
      .busy_o   (busy_o),
      .done_o   (done_o),
      .result_o (result_o)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Reference model (RISC-V division semantics)
   function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
      if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
      case (op)
         2'b00:   return $signed(a) / $signed(b);
         2'b01:   return a / b;
         2'b10:   return $signed(a) % $signed(b);
         default: return a % b;
      endcase
   endfunction

   function automatic int lat_of(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
      logic [31:0] ma, mb;
`endif
      if (b == 32'd0) return 1;
      if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef DIV_EARLY_OUT_EN
      ma = (!op[0] && a[31]) ? (~a + 32'd1) : a;
      mb = (!op[0] && b[31]) ? (~b + 32'd1) : b;
      if (ma < mb) return 1;
`endif
      return 33;
   endfunction

   // Scoreboard consumer: every done_o pops one expected result
   always @(negedge clk) begin
      if (rst_n && done_o) begin
         if (exp_q.size() == 0) begin
            check("unexpected_done", 32'(done_o), 32'd0);
         end else begin
            mon_exp = exp_q.pop_front();
            check("result", result_o, mon_exp);
            $display("op=%0d a=0x%08h b=0x%08h result=0x%08h expected=0x%08h",
                     op_i, a_i, b_i, result_o, mon_exp);
         end
      end
   end

   task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
      int lat, busy_cnt, exp_lat;
      bit got;
      exp_lat = lat_of(op, a, b);
      @(negedge clk);
      op_i = op; a_i = a; b_i = b; start_i = 1'b1;
      exp_q.push_back(exp);
      last_result = exp;
      #1;
      busy_cnt = busy_o ? 1 : 0;
      lat = 0;
      got = 0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         lat++;
         if (done_o) got = 1;
         else if (busy_o) busy_cnt++;
      end
      start_i = 1'b0;
      check("latency", 32'(lat), 32'(exp_lat));
      check("busy_cycles", 32'(busy_cnt), 32'(exp_lat));
      if (!got && exp_q.size() > 0) void'(exp_q.pop_back());
   endtask

   task automatic count_no_done(input string tag, input int cycles);
      int dones;
      dones = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (done_o) dones++;
      end
      check(tag, 32'(dones), 32'd0);
   endtask

   initial begin
      logic [1:0]  rop;
      logic [31:0] ra, rb;

      // Reset state
      repeat (2) @(negedge clk);
      check("reset_busy", 32'(busy_o), 32'd0);
      check("reset_done", 32'(done_o), 32'd0);
      check("reset_result", result_o, 32'd0);
      rst_n = 1'b1;

      // Directed cases
      do_op(2'b01, 32'd100, 32'd7, 32'd14);
      do_op(2'b11, 32'd100, 32'd7, 32'd2);
      do_op(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
      do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
      do_op(2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
      do_op(2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF);
      do_op(2'b10, 32'd5, 32'd0, 32'd5);
      do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
      do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
      do_op(2'b01, 32'd3, 32'd9, 32'd0);
      do_op(2'b10, 32'hFFFF_FFFD, 32'd9, 32'hFFFF_FFFD);
      do_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);

      // Abort 10 cycles into CALC
      @(negedge clk);
      op_i = 2'b01; a_i = 32'hFFFF_FFFF; b_i = 32'd3; start_i = 1'b1;
      repeat (11) @(negedge clk);
      abort_i = 1'b1; start_i = 1'b0;
      @(negedge clk);
      abort_i = 1'b0;
      check("abort_busy", 32'(busy_o), 32'd0);
      check("abort_done", 32'(done_o), 32'd0);
      check("abort_result_hold", result_o, last_result);
      count_no_done("abort_no_done", 40);
      do_op(2'b01, 32'd9, 32'd3, 32'd3);

      // Reset mid-CALC
      @(negedge clk);
      op_i = 2'b00; a_i = 32'd12345; b_i = 32'd17; start_i = 1'b1;
      repeat (10) @(negedge clk);
      start_i = 1'b0;
      rst_n = 1'b0;
      #1;
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_done", 32'(done_o), 32'd0);
      check("rst_result", result_o, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      count_no_done("rst_no_done", 40);
      do_op(2'b01, 32'd3, 32'd9, 32'd0);

      // Random operations against the reference model
      for (int k = 0; k < 8; k++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = (k % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
         do_op(rop, ra, rb, model(rop, ra, rb));
      end

      repeat (3) @(negedge clk);
      check("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions, sitting in the execute stage.
- It is the stall-requesting end of the hazard interface. It asserts busy_o, which the hazard unit turns into StallF/StallD/StallE.
- It obeys the hazard unit's flush via abort_i.
- The result is presented for one cycle so the instruction can advance to memory.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start_i  input  1  divide instruction valid in E (DivE & ~FlushE); held high while stalled.
op_i  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled with start.
a_i  input  XLEN  dividend (forwarded SrcAE); sampled with start.
b_i  input  XLEN  divisor (forwarded SrcBE); sampled with start.
abort_i  input  1  kill in-flight operation (branch flush/trap).
busy_o  output  1  stall request to hazard unit.
done_o  output  1  result valid this cycle.
result_o  output  XLEN  quotient or remainder, valid when done_o.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, count=0.
  - done_o=0, busy_o=0, result_o=0, all operand/working registers 0.
  - Reset mid-operation discards all work; no done_o follows.
- States: IDLE, CALC, DONE.
- busy_o = (IDLE & start_i & ~abort_i) | CALC. It is combinational, so the stall is requested in the same cycle start arrives. busy_o=0 in DONE.
- done_o = (state==DONE); result_o is a registered output.
- IDLE, start_i=1, abort_i=0 at edge:
  - Latch op, |a|, |b|, sign_a, sign_b. Signed ops take magnitudes; unsigned ops use the raw values.
  - Special cases go straight to DONE with the result loaded:
    - b==0: quotient = all ones; remainder = a.
    - DIV/REM with a=0x80000000 and b=0xFFFFFFFF: quotient = 0x80000000; remainder = 0.
  - Otherwise go to CALC with count=0, remainder reg=0, quotient reg = |a|.
- CALC, each cycle (one restoring step):
  - {rem,quo} shifted left 1; trial = rem - |b| over XLEN+1 bits.
  - If trial is non-negative: rem=trial, quo LSB=1; else quo LSB=0.
  - count increments. When count reaches XLEN-1, go to DONE.
  - Sign fix on the result load: quotient negated if sign_a^sign_b (signed op); remainder negated if sign_a (signed op).
- DONE: one cycle, then IDLE. start_i is ignored in DONE because the same instruction is leaving E.
- Latency:
  - Start sampled at edge T.
  - Normal path: busy high during cycles T..T+XLEN (XLEN+1 cycles); done_o high during cycle T+XLEN+1.
  - Special case: busy high during cycle T only; done_o high in cycle T+1.
- abort_i:
  - In any state, the next state is IDLE and done_o is not asserted.
  - abort_i has priority over start_i in the same cycle. busy_o is forced 0 in that cycle.
  - result_o holds its last value.
- start_i arriving in IDLE one cycle after DONE is treated as a new instruction.

Optional Feature:
- Macro DIV_EARLY_OUT_EN.
- When defined: in IDLE, if |a| < |b| (magnitudes, b≠0), go straight to DONE with quotient=0 and remainder=a (signs preserved).
  - Latency equals the special-case path: busy 1 cycle, done_o at T+1.
- When undefined: these operands take the full XLEN-iteration path and produce identical results.

Decomposition:
- Package div_pkg holds:
  - typedef enum div_op_e {DIV, DIVU, REM, REMU}.
  - typedef enum div_state_e {IDLE, CALC, DONE}.
  - The INT_MIN constant.
  - A function for negating a two's-complement value.
- One sub-module, div_step: a combinational single restoring iteration. Inputs: rem, quo, divisor. Outputs: next rem, next quo. It is instantiated once inside div_unit.

Test Plan:
- DIVU 100/7: busy_o high 33 cycles from start -> done_o in cycle 33 after start, result_o=14. REMU on the same operands -> 2.
- DIV -7/2 -> 0xFFFFFFFD (-3). REM -7/2 -> 0xFFFFFFFF (-1). DIV 7/-2 -> -3.
- DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5. Both give done_o the cycle after start, with busy_o high for 1 cycle only.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0. Both take 1-cycle latency.
- abort_i pulsed 10 cycles into CALC -> IDLE next cycle, busy_o=0, no done_o. A following DIVU 9/3 -> 3 after the full latency.
- rst_n pulsed low mid-CALC -> busy_o, done_o and result_o all 0 immediately. With DIV_EARLY_OUT_EN, DIVU 3/9 -> q=0 in 1 cycle; without it, q=0 after the full latency.
